// File: rtl/freq_pkg.sv
// Shared constants and FSM encoding for the frequency display formatter
// and any future BCD-based formatters.
package freq_pkg;

  localparam logic [3:0]  DP_NONE     = 4'hF;

  localparam int unsigned BIN_W       = 32;
  localparam int unsigned BCD_DIGITS  = 10;
  localparam int unsigned DISP_DIGITS = 8;
  localparam int unsigned BCD_W       = 4 * BCD_DIGITS;
  localparam int unsigned DISP_W      = 4 * DISP_DIGITS;
  localparam int unsigned SR_W        = BCD_W + BIN_W;
  localparam int unsigned ITER_W      = 5;
  localparam int unsigned SHAMT_W     = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    RANGE  = 2'd2,
    UPDATE = 2'd3
  } state_t;

  // Update payload handed to the display registers on the UPDATE edge
  typedef struct packed {
    logic [DISP_W-1:0] data;
    logic [3:0]        point;
  } disp_upd_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
// the whole {bcd, bin} register left by one.
module bcd_dabble_step
  import freq_pkg::*;
(
  input  logic [SR_W-1:0] din,
  output logic [SR_W-1:0] dout
);

  logic [SR_W-1:0] adj;

  always_comb begin
    adj = din;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (din[BIN_W + 4*i +: 4] >= 4'd5) begin
        adj[BIN_W + 4*i +: 4] = din[BIN_W + 4*i +: 4] + 4'd3;
      end
    end
    dout = adj << 1;
  end

endmodule

// File: rtl/freq_disp_fmt.sv
// Converts a binary Hz count to an auto-ranged 8-digit BCD word with a
// decimal-point index for the seven-segment scan driver.
module freq_disp_fmt
  import freq_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [BIN_W-1:0]    freq_bin,
  input  logic                freq_valid,
  output logic [DISP_W-1:0]   Disp_Data,
  output logic [3:0]          point_1,
  output logic [3:0]          point_2,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    drop_cnt
);

  state_t               state, state_nxt;
  logic [SR_W-1:0]      sr;
  logic [SR_W-1:0]      sr_step;
  logic [ITER_W-1:0]    iter;
  logic [SHAMT_W-1:0]   shamt;
  logic [BIN_W-1:0]     pend_data;
  logic                 pend_flag;

  logic                 load_new_c;
  logic                 load_pend_c;
  logic                 step_c;
  logic                 range_c;
  logic                 update_c;
  logic                 capture_c;
  logic                 drop_inc_c;
  logic [SHAMT_W-1:0]   shamt_c;
  disp_upd_t            upd_c;

  bcd_dabble_step u_step (
    .din  (sr),
    .dout (sr_step)
  );

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (freq_valid) state_nxt = SHIFT;
      SHIFT:  if (iter == ITER_W'(BIN_W - 1)) state_nxt = RANGE;
      RANGE:  state_nxt = UPDATE;
      UPDATE: state_nxt = (freq_valid || pend_flag) ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control decode; a strobe in UPDATE replaces any pending sample
  always_comb begin
    load_new_c  = 1'b0;
    load_pend_c = 1'b0;
    step_c      = 1'b0;
    range_c     = 1'b0;
    update_c    = 1'b0;
    capture_c   = 1'b0;
    unique case (state)
      IDLE:   load_new_c = freq_valid;
      SHIFT:  begin
        step_c    = 1'b1;
        capture_c = freq_valid;
      end
      RANGE:  begin
        range_c   = 1'b1;
        capture_c = freq_valid;
      end
      UPDATE: begin
        update_c    = 1'b1;
        load_new_c  = freq_valid;
        load_pend_c = !freq_valid && pend_flag;
      end
      default: ;
    endcase
    drop_inc_c = freq_valid && (state != IDLE) && pend_flag;
  end

  // Auto-range: drop up to two low digits so the leading digit fits
  always_comb begin
    if (sr[SR_W-1 -: 8] == 8'd0)      shamt_c = SHAMT_W'(0);
    else if (sr[SR_W-1 -: 4] == 4'd0) shamt_c = SHAMT_W'(1);
    else                              shamt_c = SHAMT_W'(2);
  end

  // Display word and point index for the registered shift amount
  always_comb begin
    unique case (shamt)
      SHAMT_W'(0): begin
        upd_c.data  = sr[BIN_W +: DISP_W];
        upd_c.point = DP_NONE;
      end
      SHAMT_W'(1): begin
        upd_c.data  = sr[BIN_W + 4 +: DISP_W];
        upd_c.point = 4'd2;
      end
      default: begin
        upd_c.data  = sr[BIN_W + 8 +: DISP_W];
        upd_c.point = 4'd1;
      end
    endcase
  end

  // Conversion datapath
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sr    <= '0;
      iter  <= '0;
      shamt <= '0;
    end else begin
      if (load_new_c) begin
        sr   <= {BCD_W'(0), freq_bin};
        iter <= '0;
      end else if (load_pend_c) begin
        sr   <= {BCD_W'(0), pend_data};
        iter <= '0;
      end else if (step_c) begin
        sr   <= sr_step;
        iter <= iter + ITER_W'(1);
      end
      if (range_c) shamt <= shamt_c;
    end
  end

  // Single-entry pending buffer, latest sample wins
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_data <= '0;
      pend_flag <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (capture_c) begin
        pend_data <= freq_bin;
        pend_flag <= 1'b1;
      end else if (update_c) begin
        pend_flag <= 1'b0;
      end
      if (drop_inc_c && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  // Output registers; data and point change on the same edge
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Disp_Data <= '0;
      point_1   <= DP_NONE;
      point_2   <= DP_NONE;
      done      <= 1'b0;
    end else begin
      done    <= update_c;
      point_2 <= DP_NONE;
      if (update_c) begin
        Disp_Data <= upd_c.data;
        point_1   <= upd_c.point;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
